// File: rtl/glyph_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_sequencer
//  Description : Playback controller for a 4-bit 7-segment glyph decoder.
//                A message of up to DEPTH codes is appended through a
//                ready/valid write port while IDLE. A start pulse plays the
//                message: each code is shown for HOLD cycles, then the display
//                is blanked for GAP cycles. The message plays once, ending
//                with a one-cycle done pulse, or repeats while loop is high.
//  Ports       : clk, reset (async, active-high)
//                wr_en/wr_data/wr_ready : append a glyph code (IDLE only)
//                clear  : empty the buffer and abort playback
//                start  : begin playback (IDLE with a non-empty buffer)
//                loop   : repeat instead of finishing (sampled at the end of
//                         the last glyph's gap)
//                code/blank : registered decoder drive, blank overrides code
//                busy   : playback in progress
//                done   : one-cycle pulse at the end of a non-looping playback
//  Revision    : 1.0 - initial release
// ============================================================================
module glyph_sequencer #(
    parameter int DEPTH = 8,
    parameter int HOLD  = 1000,
    parameter int GAP   = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_data,
    output logic       wr_ready,
    input  logic       clear,
    input  logic       start,
    input  logic       loop,
    output logic [3:0] code,
    output logic       blank,
    output logic       busy,
    output logic       done
);

    localparam int c_IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_LW   = c_IW + 1;
    localparam int c_TMAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int c_TW   = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;

    localparam logic [c_LW-1:0] c_DEPTH_L   = c_LW'(DEPTH);
    localparam logic [c_TW-1:0] c_HOLD_LAST = c_TW'(HOLD - 1);
    localparam logic [c_TW-1:0] c_GAP_LAST  = c_TW'(GAP - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SHOW = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    logic [1:0]      r_state,  w_state_nx;
    logic [c_LW-1:0] r_length, w_length_nx;
    logic [c_IW-1:0] r_index,  w_index_nx;
    logic [c_TW-1:0] r_timer,  w_timer_nx;
    logic [3:0]      r_code,   w_code_nx;
    logic            r_blank,  w_blank_nx;
    logic            r_busy,   w_busy_nx;
    logic            r_done,   w_done_nx;
    logic            r_wr_ready, w_wr_ready_nx;
    logic            w_mem_we;
    logic [c_IW-1:0] w_index_inc;

    // Message storage; contents are meaningless until written, so no reset.
    logic [3:0] r_mem [DEPTH];

    assign w_index_inc = r_index + 1'b1;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_length[c_IW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_length   <= '0;
            r_index    <= '0;
            r_timer    <= '0;
            r_code     <= 4'd0;
            r_blank    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_length   <= w_length_nx;
            r_index    <= w_index_nx;
            r_timer    <= w_timer_nx;
            r_code     <= w_code_nx;
            r_blank    <= w_blank_nx;
            r_busy     <= w_busy_nx;
            r_done     <= w_done_nx;
            r_wr_ready <= w_wr_ready_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_length_nx = r_length;
        w_index_nx  = r_index;
        w_timer_nx  = r_timer;
        w_code_nx   = r_code;
        w_blank_nx  = r_blank;
        w_done_nx   = 1'b0;
        w_mem_we    = 1'b0;

        if (clear) begin
            w_state_nx  = c_ST_IDLE;
            w_length_nx = '0;
            w_index_nx  = '0;
            w_timer_nx  = '0;
            w_blank_nx  = 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start && (r_length != '0)) begin
                        w_state_nx = c_ST_SHOW;
                        w_index_nx = '0;
                        w_timer_nx = '0;
                        w_code_nx  = r_mem[0];
                        w_blank_nx = 1'b0;
                    end else if (wr_en && r_wr_ready) begin
                        w_mem_we    = 1'b1;
                        w_length_nx = r_length + 1'b1;
                    end
                end
                c_ST_SHOW: begin
                    if (r_timer == c_HOLD_LAST) begin
                        w_state_nx = c_ST_GAP;
                        w_timer_nx = '0;
                        w_blank_nx = 1'b1;
                    end else begin
                        w_timer_nx = r_timer + 1'b1;
                    end
                end
                c_ST_GAP: begin
                    if (r_timer == c_GAP_LAST) begin
                        w_timer_nx = '0;
                        // length is at least 1 whenever GAP is reachable.
                        if ({1'b0, r_index} < (r_length - 1'b1)) begin
                            w_state_nx = c_ST_SHOW;
                            w_index_nx = w_index_inc;
                            w_code_nx  = r_mem[w_index_inc];
                            w_blank_nx = 1'b0;
                        end else if (loop) begin
                            w_state_nx = c_ST_SHOW;
                            w_index_nx = '0;
                            w_code_nx  = r_mem[0];
                            w_blank_nx = 1'b0;
                        end else begin
                            w_state_nx = c_ST_IDLE;
                            w_index_nx = '0;
                            w_done_nx  = 1'b1;
                        end
                    end else begin
                        w_timer_nx = r_timer + 1'b1;
                    end
                end
                default: begin
                    w_state_nx = c_ST_IDLE;
                    w_index_nx = '0;
                    w_timer_nx = '0;
                    w_blank_nx = 1'b1;
                end
            endcase
        end

        // Status flags are registered from the next-state values so they
        // line up with the state they describe.
        w_busy_nx     = (w_state_nx != c_ST_IDLE);
        w_wr_ready_nx = (w_state_nx == c_ST_IDLE) && (w_length_nx < c_DEPTH_L);
    end

    assign code     = r_code;
    assign blank    = r_blank;
    assign busy     = r_busy;
    assign done     = r_done;
    assign wr_ready = r_wr_ready;

endmodule
`default_nettype wire

// File: tb/tb_glyph_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_glyph_sequencer
//  Description : Self-checking bench for glyph_sequencer (DEPTH=8, HOLD=4,
//                GAP=2). A message/position reference model predicts every
//                output after each clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_glyph_sequencer;

    localparam int DEPTH = 8;
    localparam int HOLD  = 4;
    localparam int GAP   = 2;
    localparam int SLOT  = HOLD + GAP;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = 4'd0;
    logic       wr_ready;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       loop = 1'b0;
    logic [3:0] code;
    logic       blank;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    glyph_sequencer #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready), .clear(clear), .start(start), .loop(loop),
        .code(code), .blank(blank), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: the message as a queue, and the playback position
    // as a cycle offset t into the message (glyph t/SLOT, phase t%SLOT).
    int         m_msg[$];
    bit         m_play = 1'b0;
    int         m_t = 0;
    bit         m_done = 1'b0;
    logic [3:0] m_code = 4'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("code", 32'(code), 32'(m_code));
        chk("blank", 32'(blank), 32'(!(m_play && ((m_t % SLOT) < HOLD))));
        chk("busy", 32'(busy), 32'(m_play));
        chk("done", 32'(done), 32'(m_done));
        chk("wr_ready", 32'(wr_ready), 32'(!m_play && (m_msg.size() < DEPTH)));
    endtask

    task automatic model_edge(input bit c, input bit s, input bit w, input logic [3:0] d, input bit l);
        m_done = 1'b0;
        if (c) begin
            m_play = 1'b0;
            m_msg.delete();
        end else if (!m_play) begin
            if (s && m_msg.size() > 0) begin
                m_play = 1'b1;
                m_t    = 0;
                m_code = 4'(m_msg[0]);
            end else if (w && m_msg.size() < DEPTH) begin
                m_msg.push_back(int'(d));
            end
        end else begin
            if ((m_t % SLOT) == SLOT - 1 && (m_t / SLOT) == m_msg.size() - 1) begin
                if (l) begin
                    m_t    = 0;
                    m_code = 4'(m_msg[0]);
                end else begin
                    m_play = 1'b0;
                    m_done = 1'b1;
                end
            end else begin
                m_t++;
                if ((m_t % SLOT) == 0) m_code = 4'(m_msg[m_t / SLOT]);
            end
        end
    endtask

    // One clock: drive inputs, advance the model, then check after the edge.
    task automatic step(input bit c, input bit s, input bit w, input logic [3:0] d);
        clear   = c;
        start   = s;
        wr_en   = w;
        wr_data = d;
        model_edge(c, s, w, d, loop);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic write(input logic [3:0] d);
        step(1'b0, 1'b0, 1'b1, d);
    endtask

    // Asynchronous reset between edges; outputs must change without a clock.
    task automatic async_reset();
        reset = 1'b1;
        #2;
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_blank", 32'(blank), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        m_msg.delete();
        m_play = 1'b0;
        m_done = 1'b0;
        m_t    = 0;
        m_code = 4'd0;
        reset  = 1'b0;
    endtask

    initial begin
        int lat;
        int r;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
        idle(2);

        // Single playback of 3,1,4 with explicit done latency
        write(4'd3); write(4'd1); write(4'd4);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        lat = 0;
        for (int k = 1; k <= 3 * SLOT + 2; k++) begin
            step(1'b0, 1'b0, 1'b0, 4'd0);
            if (done && lat == 0) lat = k;
        end
        chk("done_latency", 32'(lat), 32'(3 * SLOT));

        // Replay without rewriting, with start/write attempts while busy
        step(1'b0, 1'b1, 1'b0, 4'd0);
        for (int k = 0; k < 3 * SLOT + 2; k++)
            step(1'b0, (k % 3) == 1, (k % 4) == 2, 4'hE);

        // Full buffer: 8 codes, 9th write of 0xF dropped
        step(1'b1, 1'b0, 1'b0, 4'd0);
        for (int v = 0; v < DEPTH; v++) write(4'(v));
        write(4'hF);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle(DEPTH * SLOT + 2);

        // Loop 9,2 then drop loop during the second glyph of a later pass
        step(1'b1, 1'b0, 1'b0, 4'd0);
        write(4'd9); write(4'd2);
        loop = 1'b1;
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle(4 * SLOT + 7);
        loop = 1'b0;
        idle(2 * SLOT);

        // Clear during second glyph, clear+write, start on empty buffer
        write(4'd5); write(4'd6); write(4'd7);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle(SLOT + 1);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b1, 4'hA);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle(2);

        // start+write together in IDLE: start wins
        write(4'd1); write(4'd2);
        step(1'b0, 1'b1, 1'b1, 4'd8);
        idle(2 * SLOT + 2);

        // Reset mid-SHOW, then start on the emptied buffer is ignored
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle(2);
        async_reset();
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 39) == 0) loop = ~loop;
            step(r < 2, r >= 2 && r < 8, r >= 8 && r < 45, 4'($urandom));
        end
        loop = 1'b0;
        idle(DEPTH * SLOT + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
